// File: rtl/cpu_seq_pkg.sv
// Shared state encoding, default addresses and init-address helper for the CPU host sequencer.
package cpu_seq_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INIT_WR  = 3'd1;
  localparam logic [2:0] S_INIT_GAP = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    INIT_WR  = S_INIT_WR,
    INIT_GAP = S_INIT_GAP,
    RUN      = S_RUN,
    DONE     = S_DONE
  } seq_state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0200_0000;
  localparam logic [31:0] DEF_OUT_ADDR  = 32'h0200_0000;
  localparam logic [31:0] DEF_AUX_ADDR  = 32'h0200_0004;
  localparam logic [31:0] WORD_STRIDE   = 32'd4;

  function automatic logic [31:0] init_word_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + WORD_STRIDE * {28'd0, idx};
  endfunction

endpackage

// File: rtl/result_snoop.sv
// Snoops core data-memory writes to OUT_ADDR and assembles one result bit per matching write.
module result_snoop
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] OUT_ADDR = DEF_OUT_ADDR,
  parameter int          OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic                mem_write,
  input  logic [31:0]         data_adr,
  input  logic [31:0]         write_data,
  output logic [OUT_BITS-1:0] result,
  output logic                last_bit
);

  localparam int BIDX_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [OUT_BITS-1:0] result_q, result_d;
  logic [OUT_BITS-1:0] bit_sel;
  logic                hit;
  logic                unused_wdata;

  // Only the LSB of each snooped write carries result data.
  assign unused_wdata = ^write_data[31:1];

  assign hit      = en & mem_write & (data_adr == OUT_ADDR);
  assign last_bit = hit & (bidx_q == BIDX_W'(OUT_BITS - 1));

  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_sel
    assign bit_sel[gi] = hit & (bidx_q == BIDX_W'(gi));
  end

  always_comb begin
    bidx_d   = bidx_q;
    result_d = result_q;
    if (clr) begin
      bidx_d   = '0;
      result_d = '0;
    end else if (hit) begin
      bidx_d   = bidx_q + 1'b1;
      result_d = (result_q & ~bit_sel) | (bit_sel & {OUT_BITS{write_data[0]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bidx_q   <= '0;
      result_q <= '0;
    end else begin
      bidx_q   <= bidx_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/cpu_host_sequencer.sv
// Holds the core in reset, preloads N_INIT words, releases it and snoops its result writes.
// Define CPU_SEQ_TIMEOUT_EN to add the RUN-cycle timeout abort; otherwise RUN waits forever.
module cpu_host_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int          N_INIT      = 2,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] OUT_ADDR    = DEF_OUT_ADDR,
  parameter int          OUT_BITS    = 8,
  parameter int          TIMEOUT_CYC = 1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_start,
  input  logic [32*N_INIT-1:0] init_data,
  input  logic                 mem_write,
  input  logic [31:0]          data_adr,
  input  logic [31:0]          write_data,
  output logic                 cpu_reset,
  output logic                 ext_mem_write,
  output logic [31:0]          ext_write_data,
  output logic [31:0]          ext_data_adr,
  output logic [OUT_BITS-1:0]  final_output,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  localparam int IDX_W = 4;

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_q, start_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             ext_mem_write_q, ext_mem_write_d;
  logic [31:0]      ext_write_data_q, ext_write_data_d;
  logic [31:0]      ext_data_adr_q, ext_data_adr_d;
  logic             done_q, done_d;
  logic [31:0]      sel_word;
  logic             rise, start_run, snoop_en, last_bit, tmo_hit, abort;

  assign rise = cpu_start & ~start_q;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_INIT; i++) begin
      if (idx_q == IDX_W'(i)) sel_word = init_data[32*i +: 32];
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    start_d          = cpu_start;
    cpu_reset_d      = cpu_reset_q;
    done_d           = done_q;
    ext_mem_write_d  = 1'b0;
    ext_write_data_d = '0;
    ext_data_adr_d   = '0;
    start_run        = 1'b0;
    snoop_en         = 1'b0;
    abort            = 1'b0;
    unique case (state_q)
      // DONE restarts straight into INIT_WR so a re-run costs no idle cycle.
      IDLE, DONE: begin
        cpu_reset_d = 1'b1;
        if (rise) begin
          start_run = 1'b1;
          done_d    = 1'b0;
          idx_d     = '0;
          state_d   = INIT_WR;
        end
      end
      INIT_WR: begin
        cpu_reset_d      = 1'b1;
        ext_mem_write_d  = 1'b1;
        ext_data_adr_d   = init_word_addr(BASE_ADDR, idx_q);
        ext_write_data_d = sel_word;
        state_d          = INIT_GAP;
      end
      INIT_GAP: begin
        if (idx_q == IDX_W'(N_INIT - 1)) begin
          cpu_reset_d = 1'b0;
          state_d     = RUN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = INIT_WR;
        end
      end
      RUN: begin
        snoop_en = 1'b1;
        // Final capture takes priority over a coincident timeout.
        if (last_bit) begin
          done_d      = 1'b1;
          cpu_reset_d = 1'b1;
          state_d     = DONE;
        end else if (tmo_hit) begin
          abort       = 1'b1;
          done_d      = 1'b1;
          cpu_reset_d = 1'b1;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      start_q          <= 1'b0;
      cpu_reset_q      <= 1'b1;
      ext_mem_write_q  <= 1'b0;
      ext_write_data_q <= '0;
      ext_data_adr_q   <= '0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      start_q          <= start_d;
      cpu_reset_q      <= cpu_reset_d;
      ext_mem_write_q  <= ext_mem_write_d;
      ext_write_data_q <= ext_write_data_d;
      ext_data_adr_q   <= ext_data_adr_d;
      done_q           <= done_d;
    end
  end

  result_snoop #(
    .OUT_ADDR (OUT_ADDR),
    .OUT_BITS (OUT_BITS)
  ) u_snoop (
    .clk        (clk),
    .reset      (reset),
    .clr        (start_run),
    .en         (snoop_en),
    .mem_write  (mem_write),
    .data_adr   (data_adr),
    .write_data (write_data),
    .result     (final_output),
    .last_bit   (last_bit)
  );

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;

  assign tmo_hit = (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    if (start_run) begin
      tcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (state_q == RUN) tcnt_d = tcnt_q + 1'b1;
      if (abort) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0) | abort;
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign cpu_reset      = cpu_reset_q;
  assign ext_mem_write  = ext_mem_write_q;
  assign ext_write_data = ext_write_data_q;
  assign ext_data_adr   = ext_data_adr_q;
  assign done           = done_q;
  assign busy           = (state_q == INIT_WR) || (state_q == INIT_GAP) || (state_q == RUN);

endmodule

// File: tb/tb_cpu_host_sequencer.sv
// Directed bench for cpu_host_sequencer: init preload, result capture, single-shot, timeout, reset, collision.
module tb_cpu_host_sequencer;
  import cpu_seq_pkg::*;

  localparam int          N_INIT      = 2;
  localparam int          OUT_BITS    = 8;
  localparam int          TIMEOUT_CYC = 64;
  localparam logic [31:0] BASE        = 32'h0200_0000;
  localparam logic [31:0] OUT_A       = 32'h0200_0000;

  logic                 clk = 1'b0;
  logic                 reset, cpu_start, mem_write;
  logic [32*N_INIT-1:0] init_data;
  logic [31:0]          data_adr, write_data;
  logic                 cpu_reset, ext_mem_write;
  logic [31:0]          ext_write_data, ext_data_adr;
  logic [OUT_BITS-1:0]  final_output;
  logic                 busy, done, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_host_sequencer #(
    .N_INIT      (N_INIT),
    .BASE_ADDR   (BASE),
    .OUT_ADDR    (OUT_A),
    .OUT_BITS    (OUT_BITS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_start      (cpu_start),
    .init_data      (init_data),
    .mem_write      (mem_write),
    .data_adr       (data_adr),
    .write_data     (write_data),
    .cpu_reset      (cpu_reset),
    .ext_mem_write  (ext_mem_write),
    .ext_write_data (ext_write_data),
    .ext_data_adr   (ext_data_adr),
    .final_output   (final_output),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bus();
    mem_write = 1'b0; data_adr = '0; write_data = '0;
  endtask

  task automatic snoop(input logic [31:0] a, input logic [31:0] d, input logic we);
    mem_write = we; data_adr = a; write_data = d;
    step(1);
    idle_bus();
  endtask

  task automatic begin_run();
    cpu_start = 1'b0; step(1);
    cpu_start = 1'b1; step(5);
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_start = 1'b0; idle_bus();
    init_data = {32'h0000_0005, 32'h0000_0003};
    step(3);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    n_checks++; if (ext_mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_ext_wr: got %b want 0", ext_mem_write); end
    n_checks++; if (ext_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_ext_data: got %h want 0", ext_write_data); end
    n_checks++; if (ext_data_adr !== 32'h0) begin n_fail++; $display("FAIL rst_ext_adr: got %h want 0", ext_data_adr); end
    n_checks++; if (final_output !== 8'h00) begin n_fail++; $display("FAIL rst_final: got %h want 00", final_output); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    reset = 1'b0;
    step(3);
    n_checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL idle_hold: busy=%b cpu_reset=%b want 0/1", busy, cpu_reset); end
    $display("test_reset done");
  endtask

  task automatic test_init();
    cpu_start = 1'b1;
    step(1);
    n_checks++; if (busy !== 1'b1 || ext_mem_write !== 1'b0) begin n_fail++; $display("FAIL init_entry: busy=%b wr=%b want 1/0", busy, ext_mem_write); end
    step(1);
    n_checks++; if ({ext_mem_write, ext_data_adr, ext_write_data} !== {1'b1, BASE, 32'h3}) begin n_fail++; $display("FAIL init_w0: wr=%b adr=%h data=%h want 1/%h/3", ext_mem_write, ext_data_adr, ext_write_data, BASE); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL init_rst0: got %b want 1", cpu_reset); end
    step(1);
    n_checks++; if ({ext_mem_write, ext_data_adr, ext_write_data} !== {1'b0, 32'h0, 32'h0}) begin n_fail++; $display("FAIL init_gap0: wr=%b adr=%h data=%h want 0/0/0", ext_mem_write, ext_data_adr, ext_write_data); end
    step(1);
    n_checks++; if ({ext_mem_write, ext_data_adr, ext_write_data} !== {1'b1, BASE + 32'd4, 32'h5}) begin n_fail++; $display("FAIL init_w1: wr=%b adr=%h data=%h want 1/02000004/5", ext_mem_write, ext_data_adr, ext_write_data); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL init_rst1: got %b want 1", cpu_reset); end
    step(1);
    n_checks++; if ({cpu_reset, ext_mem_write, busy} !== 3'b001) begin n_fail++; $display("FAIL run_entry: cpu_reset=%b wr=%b busy=%b want 0/0/1", cpu_reset, ext_mem_write, busy); end
    $display("test_init done");
  endtask

  task automatic test_capture();
    logic [7:0]  pat;
    logic [31:0] dec_adr;
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      snoop(OUT_A, 32'hDEAD_BEE0 | {31'h0, pat[i]}, 1'b1);
      if (i == 3) begin
        n_checks++; if (final_output !== 8'h0D) begin n_fail++; $display("FAIL cap_partial: got %h want 0d", final_output); end
      end
      if (i == 6) begin
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cap_early_done: done=%b busy=%b want 0/1", done, busy); end
      end
      if (i < 7) begin
        // Decoy LSB is the inverse of the next wanted bit, so a wrongly accepted decoy shows up.
        dec_adr = (i % 3 == 0) ? DEF_AUX_ADDR : (i % 3 == 1) ? OUT_A : 32'h8200_0000;
        snoop(dec_adr, {31'h0, ~pat[i+1]}, (i % 3 != 1));
      end
    end
    n_checks++; if (final_output !== 8'h4D) begin n_fail++; $display("FAIL cap_result: got %h want 4d", final_output); end
    n_checks++; if ({done, timeout, cpu_reset, busy} !== 4'b1010) begin n_fail++; $display("FAIL cap_done: done=%b timeout=%b cpu_reset=%b busy=%b want 1/0/1/0", done, timeout, cpu_reset, busy); end
    snoop(OUT_A, 32'h0, 1'b1);
    n_checks++; if (final_output !== 8'h4D) begin n_fail++; $display("FAIL snoop_outside_run: got %h want 4d", final_output); end
    $display("test_capture done");
  endtask

  task automatic test_single_shot();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step(1);
      if (ext_mem_write !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL single_shot: rerun_seen=%b done=%b want 0/1", seen, done); end
    cpu_start = 1'b0; step(1);
    cpu_start = 1'b1; step(1);
    n_checks++; if ({busy, done, final_output} !== {1'b1, 1'b0, 8'h00}) begin n_fail++; $display("FAIL restart: busy=%b done=%b final=%h want 1/0/00", busy, done, final_output); end
    step(1);
    n_checks++; if ({ext_mem_write, ext_data_adr} !== {1'b1, BASE}) begin n_fail++; $display("FAIL restart_w0: wr=%b adr=%h want 1/%h", ext_mem_write, ext_data_adr, BASE); end
    step(3);
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL restart_run: cpu_reset=%b want 0", cpu_reset); end
    for (int i = 0; i < 8; i++) snoop(OUT_A, 32'h1, 1'b1);
    n_checks++; if ({done, final_output} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL restart_result: done=%b final=%h want 1/ff", done, final_output); end
    $display("test_single_shot done");
  endtask

  task automatic test_timeout();
    begin_run();
    snoop(OUT_A, 32'h1, 1'b1);
    snoop(OUT_A, 32'h1, 1'b1);
    snoop(OUT_A, 32'h0, 1'b1);
    step(60);
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: done=%b busy=%b want 0/1", done, busy); end
    step(1);
`ifdef CPU_SEQ_TIMEOUT_EN
    n_checks++; if ({done, timeout, cpu_reset, busy} !== 4'b1110) begin n_fail++; $display("FAIL tmo_fire: done=%b timeout=%b cpu_reset=%b busy=%b want 1/1/1/0", done, timeout, cpu_reset, busy); end
    n_checks++; if (final_output !== 8'h03) begin n_fail++; $display("FAIL tmo_partial: got %h want 03", final_output); end
`else
    n_checks++; if ({done, timeout, busy} !== 3'b001) begin n_fail++; $display("FAIL no_tmo_wait: done=%b timeout=%b busy=%b want 0/0/1", done, timeout, busy); end
    for (int i = 0; i < 5; i++) snoop(OUT_A, 32'h1, 1'b1);
    n_checks++; if ({done, timeout, final_output} !== {2'b10, 8'hFB}) begin n_fail++; $display("FAIL no_tmo_finish: done=%b timeout=%b final=%h want 1/0/fb", done, timeout, final_output); end
`endif
    $display("test_timeout done");
  endtask

  task automatic test_collision();
    logic [7:0] coll;
    coll = 8'b1001_0110;
    begin_run();
    for (int c = 0; c < 64; c++) begin
      if (c == 22) begin
        n_checks++; if (busy !== 1'b1 || ext_mem_write !== 1'b0) begin n_fail++; $display("FAIL rise_in_run: busy=%b wr=%b want 1/0", busy, ext_mem_write); end
      end
      if (c == 63) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL coll_pre: done=%b want 0", done); end
      end
      if (c == 20) cpu_start = 1'b0;
      if (c == 21) cpu_start = 1'b1;
      if (c < 7) snoop(OUT_A, {31'h0, coll[c]}, 1'b1);
      else if (c == 63) snoop(OUT_A, {31'h0, coll[7]}, 1'b1);
      else step(1);
    end
    n_checks++; if ({done, timeout, cpu_reset} !== 3'b101) begin n_fail++; $display("FAIL collision: done=%b timeout=%b cpu_reset=%b want 1/0/1", done, timeout, cpu_reset); end
    n_checks++; if (final_output !== 8'h96) begin n_fail++; $display("FAIL coll_result: got %h want 96", final_output); end
    step(3);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL coll_hold: done=%b busy=%b want 1/0", done, busy); end
    $display("test_collision done");
  endtask

  task automatic test_reset_mid_init();
    logic [7:0] pat;
    pat = 8'hA6;
    cpu_start = 1'b0; step(1);
    cpu_start = 1'b1; step(3);
    reset = 1'b1; cpu_start = 1'b0;
    step(1);
    n_checks++; if ({ext_mem_write, cpu_reset, busy, done} !== 4'b0100) begin n_fail++; $display("FAIL mid_reset: wr=%b cpu_reset=%b busy=%b done=%b want 0/1/0/0", ext_mem_write, cpu_reset, busy, done); end
    n_checks++; if (ext_data_adr !== 32'h0 || final_output !== 8'h00) begin n_fail++; $display("FAIL mid_reset_regs: adr=%h final=%h want 0/00", ext_data_adr, final_output); end
    reset = 1'b0; step(1);
    cpu_start = 1'b1; step(2);
    n_checks++; if ({ext_mem_write, ext_data_adr, ext_write_data} !== {1'b1, BASE, 32'h3}) begin n_fail++; $display("FAIL post_rst_w0: wr=%b adr=%h data=%h want 1/%h/3", ext_mem_write, ext_data_adr, ext_write_data, BASE); end
    step(2);
    n_checks++; if ({ext_mem_write, ext_data_adr, ext_write_data} !== {1'b1, BASE + 32'd4, 32'h5}) begin n_fail++; $display("FAIL post_rst_w1: wr=%b adr=%h data=%h want 1/02000004/5", ext_mem_write, ext_data_adr, ext_write_data); end
    step(1);
    for (int i = 0; i < 8; i++) snoop(OUT_A, {31'h0, pat[i]}, 1'b1);
    n_checks++; if ({done, timeout, final_output} !== {2'b10, 8'hA6}) begin n_fail++; $display("FAIL post_rst_run: done=%b timeout=%b final=%h want 1/0/a6", done, timeout, final_output); end
    $display("test_reset_mid_init done");
  endtask

  initial begin
    test_reset();
    test_init();
    test_capture();
    test_single_shot();
    test_timeout();
    test_collision();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
